// File: rtl/snn_pkg.sv
// Shared encoder state type and frame/time defaults for the spike front end.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package snn_pkg;

    localparam int NUM_PIXELS_DEF = 320;
    localparam int T_REF_DEF      = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_EOF    = 2'd3
    } enc_state_e;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous first-word-fall-through FIFO; head data is valid whenever pop_vld_o is high.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: full_o blocks pushes unless a pop frees a slot in the same cycle.
module spike_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    output logic         full_o,
    output logic         pop_vld_o,
    output logic [W-1:0] pop_dat_o,
    input  logic         pop_rdy_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign pop_vld_o = (cnt_q != '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop    = pop_vld_o & pop_rdy_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push   = push_vld_i & (~full_o | do_pop);
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Storage array; contents need no reset because the head is qualified by pop_vld_o.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cnn_spike_encoder.sv
// Time-to-first-spike encoder: one activation per pixel in, {time, addr} spikes plus an end-of-frame token out.
// Latency: a spike appears 2 cycles after its activation is accepted when the output buffer is empty.
// Backpressure: o_act_ready drops when the output buffer is full; items hold until i_spike_ack.
module cnn_spike_encoder
    import snn_pkg::*;
#(
    parameter int  NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int  DATA_W     = 32,
    parameter int  T_REF      = T_REF_DEF,
    parameter int  FIFO_DEPTH = 4,
    localparam int ADDR_W     = $clog2(NUM_PIXELS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_act_valid,
    input  logic signed [DATA_W-1:0] i_act_data,
    output logic                     o_act_ready,
    output logic                     o_spike_valid,
    output logic signed [DATA_W-1:0] o_spike_time,
    output logic [ADDR_W-1:0]        o_spike_addr,
    output logic                     o_last_pixel_sent,
    input  logic                     i_spike_ack,
    output logic                     o_frame_done
);

    localparam logic signed [DATA_W-1:0] T_REF_S   = DATA_W'(T_REF);
    localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam int                       FW        = DATA_W + ADDR_W;

    enc_state_e               state_q, state_d;
    logic [ADDR_W-1:0]        cnt_q, cnt_d;
    logic                     enc_vld_q;
    logic signed [DATA_W-1:0] enc_time_q;
    logic [ADDR_W-1:0]        enc_addr_q;
    logic signed [DATA_W-1:0] act_time;
    logic                     act_pos;
    logic                     accept;
    logic                     in_eof;
    logic                     eof_ack;
    logic                     fifo_full;
    logic                     fifo_vld;
    logic                     fifo_pop;
    logic                     fifo_push;
    logic [FW-1:0]            fifo_dat;

    // Strictly positive activations produce spikes; zero and negative ones only advance the address.
    assign act_pos   = ~i_act_data[DATA_W-1] & (|i_act_data);
    assign in_eof    = (state_q == ST_EOF);
    assign fifo_pop  = fifo_vld & i_spike_ack;
    assign fifo_push = enc_vld_q & (~fifo_full | fifo_pop);
    // The encode stage may take a new value if it is empty or moving into the FIFO this cycle.
    assign o_act_ready = (state_q == ST_STREAM) & (~enc_vld_q | fifo_push) & ~fifo_full;
    assign accept      = i_act_valid & o_act_ready;

    // Stronger activation fires earlier; anything at or above the reference fires at time 0.
    always_comb begin
        act_time = '0;
        if (i_act_data < T_REF_S) begin
            act_time = T_REF_S - i_act_data;
        end
    end

    // Frame sequencing and pixel address counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eof_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_act_valid) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (accept) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_ADDR) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!enc_vld_q && !fifo_vld) state_d = ST_EOF;
            end
            ST_EOF: begin
                if (i_spike_ack) begin
                    eof_ack = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and address counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-deep encode stage between the input handshake and the spike buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_vld_q  <= 1'b0;
            enc_time_q <= '0;
            enc_addr_q <= '0;
        end else if (accept && act_pos) begin
            enc_vld_q  <= 1'b1;
            enc_time_q <= act_time;
            enc_addr_q <= cnt_q;
        end else if (fifo_push) begin
            enc_vld_q  <= 1'b0;
        end
    end

    spike_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_spike_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (fifo_push),
        .push_dat_i ({enc_time_q, enc_addr_q}),
        .full_o     (fifo_full),
        .pop_vld_o  (fifo_vld),
        .pop_dat_o  (fifo_dat),
        .pop_rdy_i  (i_spike_ack)
    );

    // The FIFO is always empty in EOF, so masking with fifo_vld yields the zero token fields.
    assign o_spike_valid     = in_eof | fifo_vld;
    assign o_spike_time      = fifo_vld ? fifo_dat[FW-1:ADDR_W] : '0;
    assign o_spike_addr      = fifo_vld ? fifo_dat[ADDR_W-1:0]  : '0;
    assign o_last_pixel_sent = in_eof;
    assign o_frame_done      = eof_ack;

endmodule

// File: tb/tb_cnn_spike_encoder.sv
// Randomised frame traffic against a queue-based model of the encoded spike stream.
// Latency: checks the 2-cycle acceptance-to-valid path on an empty buffer.
// Backpressure: exercises held, random and always-on downstream acks.
module tb_cnn_spike_encoder;
    import snn_pkg::*;

    localparam int NP = 320;
    localparam int DW = 32;
    localparam int TR = 1024;
    localparam int FD = 4;
    localparam int AW = $clog2(NP);

    typedef struct {
        int t;
        int a;
        bit last;
    } item_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_act_valid;
    logic signed [DW-1:0] i_act_data;
    logic                 o_act_ready;
    logic                 o_spike_valid;
    logic signed [DW-1:0] o_spike_time;
    logic [AW-1:0]        o_spike_addr;
    logic                 o_last_pixel_sent;
    logic                 i_spike_ack;
    logic                 o_frame_done;

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    acc_cnt = 0;
    int    items_rx = 0;
    int    prod_idx = -1;
    int    acc5_cyc = -1;
    int    first5_cyc = -1;
    int    ack_mode = 0;
    bit    hold = 1'b0;
    int    frame [NP];
    item_t exp_q [$];

    cnn_spike_encoder #(
        .NUM_PIXELS (NP),
        .DATA_W     (DW),
        .T_REF      (TR),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_act_valid       (i_act_valid),
        .i_act_data        (i_act_data),
        .o_act_ready       (o_act_ready),
        .o_spike_valid     (o_spike_valid),
        .o_spike_time      (o_spike_time),
        .o_spike_addr      (o_spike_addr),
        .o_last_pixel_sent (o_last_pixel_sent),
        .i_spike_ack       (i_spike_ack),
        .o_frame_done      (o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Spike time for one activation; -1 means no spike.
    function automatic int ref_time(input int a);
        if (a <= 0) return -1;
        if (a >= TR) return 0;
        return TR - a;
    endfunction

    task automatic build_exp();
        for (int i = 0; i < NP; i++) begin
            int t;
            t = ref_time(frame[i]);
            if (t >= 0) exp_q.push_back('{t: t, a: i, last: 1'b0});
        end
        exp_q.push_back('{t: 0, a: 0, last: 1'b1});
    endtask

    task automatic rand_frame(input bit skip_only);
        for (int i = 0; i < NP; i++) begin
            int k;
            k = skip_only ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
            case (k)
                0: frame[i] = -int'($urandom_range(1, 100000));
                1: frame[i] = 0;
                2: frame[i] = int'($urandom_range(1, TR - 1));
                3: frame[i] = TR;
                4: frame[i] = int'($urandom_range(TR + 1, 1000000));
                5: frame[i] = TR - 1;
                6: frame[i] = 1;
                default: frame[i] = ($urandom_range(0, 1) == 1) ? 32'sh7fff_ffff : 32'sh8000_0000;
            endcase
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after pixel hi-1 is accepted.
    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            int  waited;
            bit  taken;
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    i_act_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            prod_idx    = i;
            i_act_valid = 1'b1;
            i_act_data  = frame[i];
            waited      = 0;
            taken       = 1'b0;
            while (!taken && waited < 500) begin
                @(negedge clk);
                taken = o_act_ready;
                @(posedge clk); #1;
                waited++;
            end
            if (!taken) begin
                chk("act_accept_timeout", i, -1);
                i_act_valid = 1'b0;
                return;
            end
        end
        i_act_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int base);
        int w;
        w = 0;
        while (done_cnt == base && w < 5000) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk(tag, done_cnt - base, 1);
        chk("model_queue_drained", exp_q.size(), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && i_act_valid && o_act_ready) begin
            acc_cnt++;
            if (prod_idx == 5) acc5_cyc = cyc;
        end
    end

    // Downstream consumer: drives ack and compares every presented item with the model head.
    initial begin
        i_spike_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0:       i_spike_ack = 1'b1;
                1:       i_spike_ack = ($urandom_range(0, 1) == 1);
                default: i_spike_ack = 1'b0;
            endcase
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) chk("valid_held", o_spike_valid, 1);
                if (o_spike_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_item", 1, 0);
                    end else begin
                        chk("spike_time", o_spike_time, exp_q[0].t);
                        chk("spike_addr", o_spike_addr, exp_q[0].a);
                        chk("last_flag", o_last_pixel_sent, exp_q[0].last);
                        chk("frame_done", o_frame_done, i_spike_ack && exp_q[0].last);
                        if (!exp_q[0].last && exp_q[0].a == 5 && first5_cyc < 0) first5_cyc = cyc;
                        if (i_spike_ack) begin
                            void'(exp_q.pop_front());
                            items_rx++;
                        end
                    end
                    hold = !i_spike_ack;
                end else begin
                    chk("last_while_idle", o_last_pixel_sent, 0);
                    chk("done_while_idle", o_frame_done, 0);
                    hold = 1'b0;
                end
                if (o_frame_done) done_cnt++;
            end
        end
    end

    initial begin
        #600000;
        chk("global_timeout", 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int base;
        int rx0;
        int acc0;
        rst_n       = 1'b0;
        i_act_valid = 1'b0;
        i_act_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", o_act_ready, 0);
        chk("rst_valid", o_spike_valid, 0);
        chk("rst_time", o_spike_time, 0);
        chk("rst_addr", o_spike_addr, 0);
        chk("rst_last", o_last_pixel_sent, 0);
        chk("rst_done", o_frame_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", o_spike_valid, 0);
        chk("post_rst_ready", o_act_ready, 0);
        chk("post_rst_done", o_frame_done, 0);
        @(posedge clk); #1;

        // Dense frame, every pixel 10, ack always high.
        ack_mode = 0;
        foreach (frame[i]) frame[i] = 10;
        build_exp();
        base = done_cnt; rx0 = items_rx;
        send_range(0, NP, 1'b0);
        wait_frame("dense_frame_done", base);
        chk("dense_item_count", items_rx - rx0, NP + 1);

        // Sparse frame: one saturating spike, one negative skip.
        foreach (frame[i]) frame[i] = 0;
        frame[5] = 2000;
        frame[6] = -3;
        build_exp();
        acc5_cyc = -1; first5_cyc = -1;
        base = done_cnt; rx0 = items_rx;
        send_range(0, NP, 1'b0);
        wait_frame("sparse_frame_done", base);
        chk("sparse_item_count", items_rx - rx0, 2);
        chk("accept_to_valid_latency", first5_cyc - acc5_cyc, 2);

        // Stalled consumer: ready must drop once the buffer and encode stage are full.
        foreach (frame[i]) frame[i] = 1;
        build_exp();
        ack_mode = 2;
        base = done_cnt; rx0 = items_rx; acc0 = acc_cnt;
        fork
            send_range(0, NP, 1'b0);
            begin
                repeat (40) @(negedge clk);
                chk("stall_accept_count", acc_cnt - acc0, FD + 1);
                chk("stall_ready_low", o_act_ready, 0);
                chk("stall_valid_high", o_spike_valid, 1);
                ack_mode = 1;
            end
        join
        wait_frame("stall_frame_done", base);
        chk("stall_item_count", items_rx - rx0, NP + 1);

        // Random activations, random ack and input gaps.
        ack_mode = 1;
        rand_frame(1'b0);
        build_exp();
        base = done_cnt;
        send_range(0, NP, 1'b1);
        wait_frame("random_frame_done", base);

        // Reset mid-frame right after pixel 100 is accepted.
        rand_frame(1'b0);
        build_exp();
        send_range(0, 101, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_spike_valid, 0);
        chk("midrst_ready", o_act_ready, 0);
        chk("midrst_time", o_spike_time, 0);
        chk("midrst_addr", o_spike_addr, 0);
        chk("midrst_last", o_last_pixel_sent, 0);
        chk("midrst_done", o_frame_done, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_valid", o_spike_valid, 0);
        chk("midrst_release_ready", o_act_ready, 0);
        chk("midrst_release_done", o_frame_done, 0);
        @(posedge clk); #1;

        // Full frame after the reset must start again at address 0.
        rand_frame(1'b0);
        build_exp();
        base = done_cnt;
        send_range(0, NP, 1'b1);
        wait_frame("after_reset_frame_done", base);

        // Frame with no positive activation yields only the end-of-frame token.
        rand_frame(1'b1);
        build_exp();
        base = done_cnt; rx0 = items_rx;
        send_range(0, NP, 1'b1);
        wait_frame("skip_frame_done", base);
        chk("skip_item_count", items_rx - rx0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_spike_encoder.md
CNN_SPIKE_ENCODER -- requirements
Module: cnn_spike_encoder

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 320: activations per frame, one per spike address.
REQ-002 SHALL have parameter DATA_W, default 32: signed activation and spike-time width.
REQ-003 SHALL have parameter T_REF, default 1024: reference time for time-to-first-spike encoding.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two: depth of the spike output buffer.
REQ-005 clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_act_valid  input  1  activation present on i_act_data.
REQ-008 i_act_data  input  DATA_W signed  CNN activation, in raster order.
REQ-009 o_act_ready  output  1  encoder accepts the activation this cycle.
REQ-010 o_spike_valid  output  1  spike or end-of-frame token present.
REQ-011 o_spike_time  output  DATA_W signed  encoded spike time.
REQ-012 o_spike_addr  output  clog2(NUM_PIXELS)  pixel index of the spike.
REQ-013 o_last_pixel_sent  output  1  the presented item is the end-of-frame token.
REQ-014 i_spike_ack  input  1  downstream consumed the presented item.
REQ-015 o_frame_done  output  1  one-cycle pulse when the end-of-frame token is acked.

Function
REQ-016 SHALL accept an activation when i_act_valid & o_act_ready are high in the same cycle.
REQ-017 SHALL assign the pixel address from an internal counter, 0..NUM_PIXELS-1, incremented on every accepted activation, including skipped ones.
REQ-018 SHALL skip (emit no spike for) an activation <= 0.
REQ-019 SHALL encode an activation > 0 as time = T_REF - act, saturated at 0 when act >= T_REF; the result is always in 0..T_REF-1.
REQ-020 SHALL register the encode result in one stage, then push it into the FIFO; if the FIFO is empty, o_spike_valid rises 2 cycles after acceptance.
REQ-021 SHALL use this valid/ack handshake: o_spike_valid, time, addr and last stay stable until i_spike_ack; the item pops on the cycle ack is high; ack while valid is low is ignored.
REQ-022 SHALL drive o_act_ready = (state==STREAM) & encode stage free-or-draining & FIFO not full; no activation is ever dropped.
REQ-023 SHALL implement FSM IDLE -> STREAM on the first i_act_valid; STREAM -> FLUSH when activation NUM_PIXELS-1 is accepted; FLUSH -> EOF when the encode stage and FIFO are empty; EOF -> IDLE on i_spike_ack.
REQ-024 SHALL, in EOF, present o_spike_valid=1, o_last_pixel_sent=1, time=0, addr=0; o_last_pixel_sent is 0 in all other states.
REQ-025 SHALL pulse o_frame_done for one cycle on the EOF ack, and reset the address counter to 0 at that point.
REQ-026 SHALL, for an all-skipped frame, emit only the EOF token.
REQ-027 SHALL, when the FIFO is full and a pop and a push occur in the same cycle, perform both with no loss.
REQ-028 SHALL hold o_act_ready low in FLUSH and EOF; the next frame waits until IDLE.

Reset
REQ-029 SHALL, while rst_n is low, force state=IDLE, FIFO empty, counter=0, and all outputs to 0; an in-flight frame is discarded.
REQ-030 SHALL deassert reset with no spurious valid, ready or done pulse in the first cycle.

Structure
REQ-031 SHALL take the encoder state enum, NUM_PIXELS and T_REF defaults from a shared package, snn_pkg.
REQ-032 SHALL instantiate a single sub-module, spike_fifo (synchronous, first-word fall-through, carrying {time, addr}).

Verification
REQ-033 Activations 0..319 all = 10, ack held high -> 320 spikes, addr 0..319 in order, time 1014 each, then EOF token and one frame_done pulse.
REQ-034 act[5]=2000, act[6]=-3, all others 0 -> exactly two items: spike addr 5 time 0, then the EOF token.
REQ-035 Ack held low, act=1 streamed -> ready drops after FIFO_DEPTH+1 accepts; releasing ack restores flow with no loss and no reorder.
REQ-036 rst_n pulsed low mid-frame at pixel 100 -> outputs 0 immediately; the next frame starts at addr 0.
REQ-037 Ack asserted while valid is low, and random ack gaps -> no duplicate or dropped items; time/addr stable while valid & !ack.
